// File: rtl/pal_se_4bits_pkg.sv
// Shared constants for the pal_se_4bits PISO serialiser.
package pal_se_4bits_pkg;

    localparam int  PSE_WIDTH_DEFAULT = 4;
    localparam int  PSE_WIDTH_MIN     = 2;
    localparam int  PSE_WIDTH_MAX     = 32;
    localparam logic PSE_FILL_DEFAULT = 1'b0;

endpackage

// File: rtl/pal_se_4bits.sv
// Parallel-in, serial-out shift register: word captured on load, emitted MSB first.
module pal_se_4bits
    import pal_se_4bits_pkg::*;
#(
    parameter int   WIDTH = PSE_WIDTH_DEFAULT,
    parameter logic FILL  = PSE_FILL_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] in,
    output logic             out
);

    logic [WIDTH-1:0] sr;

    // reset wins over load, load wins over shift; shifting never stops
    always_ff @(posedge clk) begin
        if (reset)
            sr <= '0;
        else if (load)
            sr <= in;
        else
            sr <= {sr[WIDTH-2:0], FILL};
    end

    assign out = sr[WIDTH-1];

endmodule

// File: tb/tb_pal_se_4bits.sv
// Scoreboard bench for pal_se_4bits: expected bits queued at drive time, popped after each edge.
module tb_pal_se_4bits;

    logic       clk = 1'b0;
    logic       reset;
    logic       load;
    logic [3:0] in;
    logic       out;

    int checks   = 0;
    int failures = 0;
    logic sb[$];

    pal_se_4bits #(.WIDTH(4), .FILL(1'b0)) dut (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .in    (in),
        .out   (out)
    );

    always #50 clk = ~clk;

    task automatic test_reset();
        logic       rs [0:3] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic       ld [0:3] = '{1'b0, 1'b0, 1'b0, 1'b0};
        logic [3:0] dv [0:3] = '{4'b0000, 4'b1111, 4'b0101, 4'b1111};
        logic       ex [0:3] = '{1'b0, 1'b0, 1'b0, 1'b0};
        logic e;
        for (int i = 0; i < 4; i++) begin
            reset = rs[i]; load = ld[i]; in = dv[i];
            sb.push_back(ex[i]);
            @(posedge clk); #10;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL reset step %0d: scoreboard empty", i);
            end else begin
                e = sb.pop_front();
                if (out !== e) begin
                    failures++;
                    $display("FAIL reset step %0d: out=%b expected=%b", i, out, e);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_basic();
        logic       ld [0:4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [3:0] dv [0:4] = '{4'b1011, 4'b0000, 4'b1111, 4'b0000, 4'b1111};
        logic       ex [0:4] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic e;
        for (int i = 0; i < 5; i++) begin
            reset = 1'b0; load = ld[i]; in = dv[i];
            sb.push_back(ex[i]);
            @(posedge clk); #10;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL basic step %0d: scoreboard empty", i);
            end else begin
                e = sb.pop_front();
                if (out !== e) begin
                    failures++;
                    $display("FAIL basic step %0d: out=%b expected=%b", i, out, e);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reload();
        logic       ld [0:7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [3:0] dv [0:7] = '{4'b1011, 4'b1111, 4'b0000, 4'b0101,
                                 4'b1111, 4'b0000, 4'b1111, 4'b1111};
        logic       ex [0:7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic e;
        for (int i = 0; i < 8; i++) begin
            reset = 1'b0; load = ld[i]; in = dv[i];
            sb.push_back(ex[i]);
            @(posedge clk); #10;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL reload step %0d: scoreboard empty", i);
            end else begin
                e = sb.pop_front();
                if (out !== e) begin
                    failures++;
                    $display("FAIL reload step %0d: out=%b expected=%b", i, out, e);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_drain_load();
        logic       ld [0:6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [3:0] dv [0:6] = '{4'b1111, 4'b1111, 4'b1001, 4'b1111,
                                 4'b0000, 4'b1111, 4'b0000};
        logic       ex [0:6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic e;
        for (int i = 0; i < 7; i++) begin
            reset = 1'b0; load = ld[i]; in = dv[i];
            sb.push_back(ex[i]);
            @(posedge clk); #10;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL drain_load step %0d: scoreboard empty", i);
            end else begin
                e = sb.pop_front();
                if (out !== e) begin
                    failures++;
                    $display("FAIL drain_load step %0d: out=%b expected=%b", i, out, e);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_priority();
        logic       rs [0:3] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic       ld [0:3] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [3:0] dv [0:3] = '{4'b1111, 4'b1111, 4'b1111, 4'b1111};
        logic       ex [0:3] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic e;
        for (int i = 0; i < 4; i++) begin
            reset = rs[i]; load = ld[i]; in = dv[i];
            sb.push_back(ex[i]);
            @(posedge clk); #10;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL priority step %0d: scoreboard empty", i);
            end else begin
                e = sb.pop_front();
                if (out !== e) begin
                    failures++;
                    $display("FAIL priority step %0d: out=%b expected=%b", i, out, e);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_midword();
        logic       rs [0:4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic       ld [0:4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [3:0] dv [0:4] = '{4'b1101, 4'b0000, 4'b1111, 4'b1111, 4'b1111};
        logic       ex [0:4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic e;
        for (int i = 0; i < 5; i++) begin
            reset = rs[i]; load = ld[i]; in = dv[i];
            sb.push_back(ex[i]);
            @(posedge clk); #10;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL reset_midword step %0d: scoreboard empty", i);
            end else begin
                e = sb.pop_front();
                if (out !== e) begin
                    failures++;
                    $display("FAIL reset_midword step %0d: out=%b expected=%b", i, out, e);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic       ld [0:6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [3:0] dv [0:6] = '{4'b1000, 4'b0111, 4'b1010, 4'b1111,
                                 4'b1111, 4'b1111, 4'b1111};
        logic       ex [0:6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic e;
        for (int i = 0; i < 7; i++) begin
            reset = 1'b0; load = ld[i]; in = dv[i];
            sb.push_back(ex[i]);
            @(posedge clk); #10;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL back_to_back step %0d: scoreboard empty", i);
            end else begin
                e = sb.pop_front();
                if (out !== e) begin
                    failures++;
                    $display("FAIL back_to_back step %0d: out=%b expected=%b", i, out, e);
                end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b1;
        load  = 1'b0;
        in    = 4'b0000;
        test_reset();
        test_basic();
        test_reload();
        test_drain_load();
        test_priority();
        test_reset_midword();
        test_back_to_back();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: left=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
